// File: rtl/pll_md_pkg.sv
// Shared constants for the PLL MD-port responder: opcodes, register map
// addresses, control/status bit positions and a status-byte helper.
package pll_md_pkg;

    localparam logic [1:0] OPC_IDLE = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] OPC_ADDR = 2'b11;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_FBDIV  = 8'h01;
    localparam logic [7:0] REG_IDIV   = 8'h02;
    localparam logic [7:0] REG_ODIV0  = 8'h03;
    localparam logic [7:0] REG_ODIV1  = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h05;
    localparam logic [7:0] REG_ID     = 8'h3F;

    localparam int CTRL_SOFT_RST_BIT = 0;
    localparam int CTRL_APPLY_BIT    = 1;
    localparam int STATUS_LOCK_BIT   = 0;
    localparam int STATUS_BUSY_BIT   = 1;

    // Pack lock/busy into the STATUS register layout.
    function automatic logic [7:0] status_byte(input logic lock_in, input logic busy_in);
        logic [7:0] s;
        s = 8'h00;
        s[STATUS_LOCK_BIT] = lock_in;
        s[STATUS_BUSY_BIT] = busy_in;
        return s;
    endfunction

endpackage

// File: rtl/pll_md_lock_timer.sv
// Relock model: after reset release or a start pulse, lock stays low for
// RELOCK_CYCLES counting edges. Counting freezes while hold is high.
module pll_md_lock_timer #(
    parameter int RELOCK_CYCLES = 1000
) (
    input  logic mdclk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic lock,
    output logic busy
);

    // A zero-cycle relock still needs a one-bit counter to exist.
    localparam int CNT_W = (RELOCK_CYCLES > 0) ? $clog2(RELOCK_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             lock_next;

    // Counter/lock next state: start restarts, hold freezes, 1->0 raises lock.
    always_comb begin
        count_next = count;
        lock_next  = lock;
        if (start) begin
            count_next = CNT_INIT;
            lock_next  = 1'b0;
        end else if (count == CNT_ZERO) begin
            lock_next  = 1'b1;
        end else if (!hold) begin
            count_next = count - CNT_ONE;
            lock_next  = (count == CNT_ONE);
        end else begin
            count_next = count;
            lock_next  = lock;
        end
    end

    // Counter and lock state registers.
    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            count <= CNT_INIT;
            lock  <= 1'b0;
        end else begin
            count <= count_next;
            lock  <= lock_next;
        end
    end

    assign busy = (count != CNT_ZERO);

endmodule

// File: rtl/pll_md_responder.sv
// Slave end of the PLL MD reconfiguration bus: register bank with an
// auto-increment pointer, shadow/active divider sets and a modelled lock.
module pll_md_responder
    import pll_md_pkg::*;
#(
    parameter int         ADDR_W        = 6,
    parameter int         RELOCK_CYCLES = 1000,
    parameter logic [7:0] FBDIV_DEF     = 8'd40,
    parameter logic [7:0] IDIV_DEF      = 8'd1,
    parameter logic [7:0] ODIV0_DEF     = 8'd8,
    parameter logic [7:0] ODIV1_DEF     = 8'd4,
    parameter logic [7:0] ID_VALUE      = 8'hA5
) (
    input  logic       mdclk,
    input  logic       reset,
    input  logic [1:0] mdopc,
    input  logic       mdainc,
    input  logic [7:0] mdwdi,
    output logic [7:0] mdrdo,
    output logic       lock,
    output logic [7:0] cfg_fbdiv,
    output logic [7:0] cfg_idiv,
    output logic [7:0] cfg_odiv0,
    output logic [7:0] cfg_odiv1,
    output logic       cfg_rst
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        addr_ext;
    logic              soft_rst;
    logic              apply_pend;
    logic [7:0]        shadow_fbdiv;
    logic [7:0]        shadow_idiv;
    logic [7:0]        shadow_odiv0;
    logic [7:0]        shadow_odiv1;
    logic [7:0]        rd_data;
    logic              busy;
    logic              wr_en;
    logic              rd_en;

    assign addr_ext = 8'(addr);
    assign wr_en    = (mdopc == OPC_WR);
    assign rd_en    = (mdopc == OPC_RD);

    // Pointer update: load on ADDR, optional post-increment on WR/RD.
    always_comb begin
        addr_next = addr;
        case (mdopc)
            OPC_ADDR: addr_next = mdwdi[ADDR_W-1:0];
            OPC_WR,
            OPC_RD: begin
                if (mdainc) begin
                    addr_next = addr + ADDR_ONE;
                end else begin
                    addr_next = addr;
                end
            end
            default: addr_next = addr;
        endcase
    end

    // Read mux; apply reads back as 0 and STATUS reflects the current edge.
    always_comb begin
        rd_data = 8'h00;
        case (addr_ext)
            REG_CTRL:   rd_data = {7'b0000000, soft_rst};
            REG_FBDIV:  rd_data = shadow_fbdiv;
            REG_IDIV:   rd_data = shadow_idiv;
            REG_ODIV0:  rd_data = shadow_odiv0;
            REG_ODIV1:  rd_data = shadow_odiv1;
            REG_STATUS: rd_data = status_byte(lock, busy);
            REG_ID:     rd_data = ID_VALUE;
            default:    rd_data = 8'h00;
        endcase
    end

    // Address pointer register.
    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else begin
            addr <= addr_next;
        end
    end

    // Read data register; holds its value when not reading.
    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            mdrdo <= 8'h00;
        end else if (rd_en) begin
            mdrdo <= rd_data;
        end
    end

    // Writable registers: CTRL soft reset and the four shadow dividers.
    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            soft_rst     <= 1'b0;
            shadow_fbdiv <= FBDIV_DEF;
            shadow_idiv  <= IDIV_DEF;
            shadow_odiv0 <= ODIV0_DEF;
            shadow_odiv1 <= ODIV1_DEF;
        end else if (wr_en) begin
            case (addr_ext)
                REG_CTRL:  soft_rst     <= mdwdi[CTRL_SOFT_RST_BIT];
                REG_FBDIV: shadow_fbdiv <= mdwdi;
                REG_IDIV:  shadow_idiv  <= mdwdi;
                REG_ODIV0: shadow_odiv0 <= mdwdi;
                REG_ODIV1: shadow_odiv1 <= mdwdi;
                default:   soft_rst     <= soft_rst;
            endcase
        end
    end

    // Apply pulse and registered core-reset request.
    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            apply_pend <= 1'b0;
            cfg_rst    <= 1'b0;
        end else begin
            apply_pend <= wr_en && (addr_ext == REG_CTRL) && mdwdi[CTRL_APPLY_BIT];
            cfg_rst    <= soft_rst;
        end
    end

    // Active dividers take the shadow values one edge after an apply write,
    // so a shadow write landing on that edge is not picked up.
    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            cfg_fbdiv <= FBDIV_DEF;
            cfg_idiv  <= IDIV_DEF;
            cfg_odiv0 <= ODIV0_DEF;
            cfg_odiv1 <= ODIV1_DEF;
        end else if (apply_pend) begin
            cfg_fbdiv <= shadow_fbdiv;
            cfg_idiv  <= shadow_idiv;
            cfg_odiv0 <= shadow_odiv0;
            cfg_odiv1 <= shadow_odiv1;
        end
    end

    pll_md_lock_timer #(
        .RELOCK_CYCLES (RELOCK_CYCLES)
    ) u_lock_timer (
        .mdclk (mdclk),
        .reset (reset),
        .start (apply_pend),
        .hold  (soft_rst),
        .lock  (lock),
        .busy  (busy)
    );

endmodule

// File: tb/tb_pll_md_responder.sv
// Scoreboard bench for pll_md_responder: a transaction-level model predicts
// the outputs after every edge, a negedge monitor compares them.
module tb_pll_md_responder;
    import pll_md_pkg::*;

    localparam int RELOCK = 16;

    logic       mdclk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mdopc = 2'b00;
    logic       mdainc = 1'b0;
    logic [7:0] mdwdi = 8'h00;
    logic [7:0] mdrdo;
    logic       lock;
    logic [7:0] cfg_fbdiv, cfg_idiv, cfg_odiv0, cfg_odiv1;
    logic       cfg_rst;

    pll_md_responder #(
        .ADDR_W        (6),
        .RELOCK_CYCLES (RELOCK)
    ) dut (
        .mdclk     (mdclk),
        .reset     (reset),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo),
        .lock      (lock),
        .cfg_fbdiv (cfg_fbdiv),
        .cfg_idiv  (cfg_idiv),
        .cfg_odiv0 (cfg_odiv0),
        .cfg_odiv1 (cfg_odiv1),
        .cfg_rst   (cfg_rst)
    );

    always #5 mdclk = ~mdclk;

    typedef struct packed {
        logic [7:0] rdo;
        logic       lk;
        logic [7:0] fb;
        logic [7:0] idv;
        logic [7:0] o0;
        logic [7:0] o1;
        logic       crst;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int         m_addr;
    logic [7:0] m_rdo;
    logic       m_lock;
    logic       m_crst;
    logic       m_soft;
    logic       m_apply;
    int         m_left;
    logic [7:0] m_shadow [1:4];
    logic [7:0] m_active [1:4];

    function automatic logic [7:0] def_val(input int i);
        case (i)
            1: return 8'd40;
            2: return 8'd1;
            3: return 8'd8;
            default: return 8'd4;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_rdo = 8'h00; m_lock = 1'b0; m_crst = 1'b0;
        m_soft = 1'b0; m_apply = 1'b0; m_left = RELOCK;
        for (int i = 1; i <= 4; i++) begin
            m_shadow[i] = def_val(i);
            m_active[i] = def_val(i);
        end
    endtask

    function automatic logic [7:0] model_read(input int a, input logic lk, input logic bz, input logic sf);
        if (a == 0) return {7'd0, sf};
        if (a >= 1 && a <= 4) return m_shadow[a];
        if (a == 5) return {6'd0, bz, lk};
        if (a == 63) return 8'hA5;
        return 8'h00;
    endfunction

    // One clock edge of the register map / relock behaviour, using pre-edge values.
    task automatic model_step(input logic [1:0] opc, input logic ainc, input logic [7:0] wdi);
        logic s_lock, s_busy, s_soft, s_apply;
        int   a;
        s_lock = m_lock; s_busy = (m_left != 0); s_soft = m_soft; s_apply = m_apply;
        a = m_addr;
        m_crst  = s_soft;
        m_apply = 1'b0;
        if (s_apply) begin
            for (int i = 1; i <= 4; i++) m_active[i] = m_shadow[i];
            m_lock = 1'b0;
            m_left = RELOCK;
        end else if (m_left == 0) begin
            m_lock = 1'b1;
        end else if (!s_soft) begin
            m_left = m_left - 1;
            if (m_left == 0) m_lock = 1'b1;
        end
        case (opc)
            2'b11: m_addr = int'(wdi) % 64;
            2'b01: begin
                if (a == 0) begin
                    m_soft  = wdi[0];
                    m_apply = wdi[1];
                end else if (a >= 1 && a <= 4) begin
                    m_shadow[a] = wdi;
                end
                if (ainc) m_addr = (a + 1) % 64;
            end
            2'b10: begin
                m_rdo = model_read(a, s_lock, s_busy, s_soft);
                if (ainc) m_addr = (a + 1) % 64;
            end
            default: ;
        endcase
    endtask

    // Drive one cycle, advance the model at the edge and queue the prediction.
    task automatic cyc(input logic [1:0] opc, input logic ainc, input logic [7:0] wdi);
        exp_t e;
        mdopc = opc; mdainc = ainc; mdwdi = wdi;
        @(posedge mdclk);
        if (reset) model_reset();
        else       model_step(opc, ainc, wdi);
        e.rdo = m_rdo; e.lk = m_lock; e.fb = m_active[1]; e.idv = m_active[2];
        e.o0 = m_active[3]; e.o1 = m_active[4]; e.crst = m_crst;
        expq.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(OPC_IDLE, 1'b0, 8'h00);
    endtask

    // Asynchronous reset mid-cycle: outputs must return to reset values at once.
    task automatic do_reset();
        @(negedge mdclk);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_now_mdrdo", mdrdo, 8'h00);
        check("rst_now_lock", {7'd0, lock}, 8'h00);
        check("rst_now_fbdiv", cfg_fbdiv, 8'd40);
        check("rst_now_idiv", cfg_idiv, 8'd1);
        check("rst_now_cfg_rst", {7'd0, cfg_rst}, 8'h00);
        cyc(OPC_IDLE, 1'b0, 8'h00);
        reset = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the oldest prediction.
    always @(negedge mdclk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check("sb_mdrdo", mdrdo, mon_e.rdo);
            check("sb_lock", {7'd0, lock}, {7'd0, mon_e.lk});
            check("sb_fbdiv", cfg_fbdiv, mon_e.fb);
            check("sb_idiv", cfg_idiv, mon_e.idv);
            check("sb_odiv0", cfg_odiv0, mon_e.o0);
            check("sb_odiv1", cfg_odiv1, mon_e.o1);
            check("sb_cfg_rst", {7'd0, cfg_rst}, {7'd0, mon_e.crst});
        end
    end

    initial begin
        logic [7:0] w;
        int         sel;

        // Reset held for two edges, then released
        idle(2);
        check("t1_rst_mdrdo", mdrdo, 8'h00);
        check("t1_rst_fbdiv", cfg_fbdiv, 8'd40);
        check("t1_rst_idiv", cfg_idiv, 8'd1);
        reset = 1'b0;
        idle(15);
        check("t1_lock_low15", {7'd0, lock}, 8'h00);
        idle(1);
        check("t1_lock_high16", {7'd0, lock}, 8'h01);

        // Write FBDIV/IDIV with auto-increment, read them back
        cyc(OPC_ADDR, 1'b0, 8'h01);
        cyc(OPC_WR, 1'b1, 8'h32);
        cyc(OPC_WR, 1'b0, 8'h02);
        cyc(OPC_ADDR, 1'b0, 8'h01);
        cyc(OPC_RD, 1'b1, 8'h00);
        check("t2_rd_fbdiv", mdrdo, 8'h32);
        cyc(OPC_RD, 1'b0, 8'h00);
        check("t2_rd_idiv", mdrdo, 8'h02);

        // Apply and relock
        cyc(OPC_ADDR, 1'b0, 8'h00);
        cyc(OPC_WR, 1'b0, 8'h02);
        idle(1);
        check("t3_lock_dropped", {7'd0, lock}, 8'h00);
        check("t3_fbdiv", cfg_fbdiv, 8'h32);
        check("t3_idiv", cfg_idiv, 8'h02);
        idle(15);
        check("t3_lock_low", {7'd0, lock}, 8'h00);
        idle(1);
        check("t3_lock_high", {7'd0, lock}, 8'h01);
        cyc(OPC_RD, 1'b0, 8'h00);
        check("t3_ctrl_reads0", mdrdo, 8'h00);

        // ID read, pointer wrap, STATUS
        cyc(OPC_ADDR, 1'b0, 8'h3F);
        cyc(OPC_RD, 1'b1, 8'h00);
        check("t4_id", mdrdo, 8'hA5);
        cyc(OPC_RD, 1'b1, 8'h00);
        check("t4_wrap_ctrl", mdrdo, 8'h00);
        cyc(OPC_ADDR, 1'b0, 8'h05);
        cyc(OPC_RD, 1'b0, 8'h00);
        check("t4_status", mdrdo, 8'h01);

        // Apply, freeze with soft_rst, release
        cyc(OPC_ADDR, 1'b0, 8'h00);
        cyc(OPC_WR, 1'b0, 8'h02);
        idle(8);
        cyc(OPC_WR, 1'b0, 8'h01);
        idle(10);
        check("t5_cfg_rst", {7'd0, cfg_rst}, 8'h01);
        check("t5_lock_frozen", {7'd0, lock}, 8'h00);
        cyc(OPC_WR, 1'b0, 8'h00);
        idle(7);
        check("t5_lock_still_low", {7'd0, lock}, 8'h00);
        idle(1);
        check("t5_lock_rise", {7'd0, lock}, 8'h01);

        // Apply then reset mid-relock
        cyc(OPC_WR, 1'b0, 8'h02);
        idle(5);
        do_reset();
        idle(3);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                sel = $urandom_range(0, 3);
                w   = 8'($urandom);
                if (sel == 3) begin
                    case ($urandom_range(0, 7))
                        0, 1, 2, 3, 4, 5: w = 8'($urandom_range(0, 5));
                        6: w = 8'h3F;
                        default: w = 8'($urandom_range(6, 62)) | (8'($urandom_range(0, 3)) << 6);
                    endcase
                end else if (sel == 1 && m_addr == 0) begin
                    w = {6'd0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0)};
                end
                cyc(2'(sel), 1'($urandom_range(0, 1)), w);
            end
        end
        idle(2);
        @(negedge mdclk);
        #1;
        check("queue_drain", 8'(expq.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
